// File: rtl/m_wb_pkg.sv
// m_wb_pkg: shared types and defaults for the M-unit writeback merge.
package m_wb_pkg;
  localparam int DEFAULT_DEPTH = 2;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;
endpackage

// File: rtl/m_wb_merge_if.sv
// m_wb_merge_if: M-unit result, pipeline writeback and register-file port bundle.
interface m_wb_merge_if import m_wb_pkg::*; #(parameter int DEPTH = DEFAULT_DEPTH) ();
  logic                     m_ready;
  logic                     m_wr;
  logic [31:0]              m_result;
  logic [4:0]               m_rd;
  logic                     p_wr_en;
  logic [4:0]               p_rd;
  logic [31:0]              p_data;
  logic                     rf_we;
  logic [4:0]               rf_waddr;
  logic [31:0]              rf_wdata;
  logic                     stall_wb;
  logic                     pending_valid;
  logic [4:0]               pending_rd;
  logic [$clog2(DEPTH):0]   pending_count;
  modport master (
    output m_ready, m_wr, m_result, m_rd, p_wr_en, p_rd, p_data,
    input  rf_we, rf_waddr, rf_wdata, stall_wb, pending_valid, pending_rd, pending_count
  );
  modport slave (
    input  m_ready, m_wr, m_result, m_rd, p_wr_en, p_rd, p_data,
    output rf_we, rf_waddr, rf_wdata, stall_wb, pending_valid, pending_rd, pending_count
  );
endinterface

// File: rtl/m_wb_fifo.sv
// m_wb_fifo: ordered M-result buffer with kill-by-rd; dead entries at the head are skipped.
module m_wb_fifo import m_wb_pkg::*; #(parameter int DEPTH = DEFAULT_DEPTH) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [4:0]             push_rd,
  input  logic [31:0]            push_data,
  input  logic                   pop,
  input  logic                   kill,
  input  logic [4:0]             kill_rd,
  output logic                   head_valid,
  output logic [4:0]             head_rd,
  output logic [31:0]            head_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] live_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, head_ptr;
  logic [CW-1:0]     occ_q, occ_d, skip, eff_occ;
  // skip counts killed slots in front of the first live entry; they are freed without a write cycle
  always_comb begin
    skip = occ_q;
    head_valid = 1'b0;
    live_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_count = live_count + CW'(mem_q[i].valid);
      if (!head_valid && CW'(i) < occ_q && mem_q[rd_ptr_q + PW'(i)].valid) begin
        skip = CW'(i);
        head_valid = 1'b1;
      end
    end
    head_ptr = rd_ptr_q + skip[PW-1:0];
    eff_occ = occ_q - skip;
    head_rd = mem_q[head_ptr].rd;
    head_data = mem_q[head_ptr].data;
    full = eff_occ == CW'(DEPTH);
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++)
      if (kill && mem_q[i].rd == kill_rd) mem_d[i].valid = 1'b0;
    if (pop) mem_d[head_ptr].valid = 1'b0;
    if (push) mem_d[wr_ptr_q] = '{valid: 1'b1, rd: push_rd, data: push_data};
    rd_ptr_d = head_ptr + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    occ_d = eff_occ - CW'(pop) + CW'(push);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q <= occ_d;
    end
  end
endmodule

// File: rtl/m_wb_merge.sv
// m_wb_merge: arbitrates one register-file write per cycle between the pipeline and M-unit results.
module m_wb_merge import m_wb_pkg::*; #(parameter int DEPTH = DEFAULT_DEPTH) (
  input logic         clk,
  input logic         resetn,
  m_wb_merge_if.slave bus
);
  logic                   m_acc, p_req, full, head_valid, push, pop, kill;
  logic                   rf_we, stall;
  logic [4:0]             head_rd, rf_waddr;
  logic [31:0]            head_data, rf_wdata;
  logic [$clog2(DEPTH):0] live_count;
  assign m_acc = bus.m_ready && bus.m_wr && bus.m_rd != 5'd0;
  assign p_req = bus.p_wr_en && bus.p_rd != 5'd0;
  m_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .resetn(resetn),
    .push(push), .push_rd(bus.m_rd), .push_data(bus.m_result),
    .pop(pop), .kill(kill), .kill_rd(bus.p_rd),
    .head_valid(head_valid), .head_rd(head_rd), .head_data(head_data),
    .full(full), .live_count(live_count)
  );
  // a performed pipeline write is younger than anything M produced, so it kills matching M results
  always_comb begin
    rf_we = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    stall = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    kill = 1'b0;
    if (resetn) begin
      if (full) begin
        {rf_we, rf_waddr, rf_wdata, pop} = {1'b1, head_rd, head_data, 1'b1};
        push = m_acc;
        stall = p_req;
      end else if (p_req) begin
        {rf_we, rf_waddr, rf_wdata, kill} = {1'b1, bus.p_rd, bus.p_data, 1'b1};
        push = m_acc && bus.m_rd != bus.p_rd;
      end else if (head_valid) begin
        {rf_we, rf_waddr, rf_wdata, pop} = {1'b1, head_rd, head_data, 1'b1};
        push = m_acc;
      end else if (m_acc) begin
        {rf_we, rf_waddr, rf_wdata} = {1'b1, bus.m_rd, bus.m_result};
      end
    end
  end
  assign bus.rf_we = rf_we;
  assign bus.rf_waddr = rf_waddr;
  assign bus.rf_wdata = rf_wdata;
  assign bus.stall_wb = stall;
  assign bus.pending_valid = resetn && head_valid;
  assign bus.pending_rd = (resetn && head_valid) ? head_rd : 5'd0;
  assign bus.pending_count = resetn ? live_count : '0;
endmodule

// File: tb/tb_m_wb_merge.sv
// tb_m_wb_merge: directed checks of bypass, buffering, priority, kill and reset behaviour.
module tb_m_wb_merge;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  m_wb_merge_if #(.DEPTH(2)) bus ();
  m_wb_merge #(.DEPTH(2)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic pv, input logic [4:0] prd, input logic [31:0] pd);
    bus.m_ready = mv;
    bus.m_wr = mv;
    bus.m_rd = mrd;
    bus.m_result = md;
    bus.p_wr_en = pv;
    bus.p_rd = prd;
    bus.p_data = pd;
    #1;
  endtask
  task automatic idle();
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, 32'(bus.rf_we), 32'(we));
    if (we) begin
      chk({tag, ".addr"}, 32'(bus.rf_waddr), 32'(a));
      chk({tag, ".data"}, bus.rf_wdata, d);
    end
  endtask
  task automatic chk_pend(input string tag, input logic v, input logic [4:0] rd, input int cnt);
    chk({tag, ".pv"}, 32'(bus.pending_valid), 32'(v));
    chk({tag, ".prd"}, 32'(bus.pending_rd), 32'(rd));
    chk({tag, ".cnt"}, 32'(bus.pending_count), 32'(cnt));
  endtask
  task automatic fill_two();
    drv(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    chk_wr("fill.a", 1'b1, 5'd2, 32'h22);
    tick();
    drv(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88);
    chk_wr("fill.b", 1'b1, 5'd8, 32'h88);
    tick();
    idle();
    chk_pend("fill.full", 1'b1, 5'd1, 2);
  endtask
  initial begin
    drv(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd3, 32'hBEEF);
    tick();
    tick();
    chk_wr("rst.hold", 1'b0, 5'd0, 32'h0);
    chk("rst.stall", 32'(bus.stall_wb), 32'd0);
    chk_pend("rst.pend", 1'b0, 5'd0, 0);
    resetn = 1'b1;
    idle();
    chk_wr("idle", 1'b0, 5'd0, 32'h0);
    chk_pend("idle", 1'b0, 5'd0, 0);
    // zero-latency bypass
    drv(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0);
    chk_wr("bypass", 1'b1, 5'd5, 32'h12345678);
    tick();
    idle();
    chk_pend("bypass.after", 1'b0, 5'd0, 0);
    // m_ready without m_wr is not a result
    drv(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
    bus.m_wr = 1'b0;
    #1;
    chk_wr("nowr", 1'b0, 5'd0, 32'h0);
    tick();
    idle();
    chk_pend("nowr.after", 1'b0, 5'd0, 0);
    // x0 never written
    drv(1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h77);
    chk_wr("x0", 1'b0, 5'd0, 32'h0);
    tick();
    idle();
    chk_pend("x0.after", 1'b0, 5'd0, 0);
    // collision: pipeline first, M result next cycle
    drv(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    chk_wr("coll.c0", 1'b1, 5'd4, 32'h44);
    tick();
    idle();
    chk_pend("coll.c1", 1'b1, 5'd3, 1);
    chk_wr("coll.c1", 1'b1, 5'd3, 32'h33);
    tick();
    chk_pend("coll.c2", 1'b0, 5'd0, 0);
    chk_wr("coll.c2", 1'b0, 5'd0, 32'h0);
    // full buffer stalls the pipeline
    fill_two();
    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
    chk("full.stall", 32'(bus.stall_wb), 32'd1);
    chk_wr("full.head", 1'b1, 5'd1, 32'h11);
    tick();
    chk("full.unstall", 32'(bus.stall_wb), 32'd0);
    chk_wr("full.p7", 1'b1, 5'd7, 32'h77);
    tick();
    idle();
    chk_wr("full.drain", 1'b1, 5'd6, 32'h66);
    tick();
    chk_pend("full.empty", 1'b0, 5'd0, 0);
    // kill: younger pipeline write overrides buffered M result
    drv(1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd10, 32'h1010);
    chk_wr("kill.c0", 1'b1, 5'd10, 32'h1010);
    tick();
    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hBBBB);
    chk_wr("kill.c1", 1'b1, 5'd9, 32'hBBBB);
    tick();
    idle();
    chk_wr("kill.c2", 1'b0, 5'd0, 32'h0);
    chk_pend("kill.c2", 1'b0, 5'd0, 0);
    // killed head is skipped without a write cycle
    drv(1'b1, 5'd11, 32'hB1, 1'b1, 5'd13, 32'hD13);
    chk_wr("skip.c0", 1'b1, 5'd13, 32'hD13);
    tick();
    drv(1'b1, 5'd12, 32'hC2, 1'b1, 5'd11, 32'hE11);
    chk_wr("skip.c1", 1'b1, 5'd11, 32'hE11);
    tick();
    idle();
    chk_pend("skip.c2", 1'b1, 5'd12, 1);
    chk_wr("skip.c2", 1'b1, 5'd12, 32'hC2);
    tick();
    chk_pend("skip.c3", 1'b0, 5'd0, 0);
    // same-rd M result discarded when pipeline writes
    drv(1'b1, 5'd14, 32'hE0E0, 1'b1, 5'd14, 32'hF0F0);
    chk_wr("same.c0", 1'b1, 5'd14, 32'hF0F0);
    tick();
    idle();
    chk_wr("same.c1", 1'b0, 5'd0, 32'h0);
    chk_pend("same.c1", 1'b0, 5'd0, 0);
    // push and pop together while full
    fill_two();
    drv(1'b1, 5'd15, 32'hF15, 1'b0, 5'd0, 32'h0);
    chk_wr("pp.c0", 1'b1, 5'd1, 32'h11);
    tick();
    idle();
    chk_pend("pp.c1", 1'b1, 5'd6, 2);
    chk_wr("pp.c1", 1'b1, 5'd6, 32'h66);
    tick();
    chk_wr("pp.c2", 1'b1, 5'd15, 32'hF15);
    tick();
    chk_pend("pp.c3", 1'b0, 5'd0, 0);
    // reset while full discards everything
    fill_two();
    resetn = 1'b0;
    #1;
    chk_wr("rstfull.hold", 1'b0, 5'd0, 32'h0);
    chk_pend("rstfull.hold", 1'b0, 5'd0, 0);
    tick();
    resetn = 1'b1;
    #1;
    chk_wr("rstfull.after", 1'b0, 5'd0, 32'h0);
    chk_pend("rstfull.after", 1'b0, 5'd0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/m_wb_merge.md
M_WB_MERGE -- requirements
Module: m_wb_merge

Interface
REQ-001 SHALL have parameter DEPTH, default 2, M-result buffer entries (power of two, >=2).
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have m_ready  input  1  M-unit result-valid strobe.
REQ-005 SHALL have m_wr  input  1  M-unit write-enable; result accepted only when m_ready && m_wr.
REQ-006 SHALL have m_result  input  32  M-unit result data.
REQ-007 SHALL have m_rd  input  5  M-unit destination register.
REQ-008 SHALL have p_wr_en  input  1  main-pipeline writeback request.
REQ-009 SHALL have p_rd  input  5  main-pipeline destination register.
REQ-010 SHALL have p_data  input  32  main-pipeline writeback data.
REQ-011 SHALL have rf_we  output  1  register-file write enable.
REQ-012 SHALL have rf_waddr  output  5  register-file write address.
REQ-013 SHALL have rf_wdata  output  32  register-file write data.
REQ-014 SHALL have stall_wb  output  1  pipeline writeback not accepted this cycle; hold it.
REQ-015 SHALL have pending_valid  output  1  buffer holds at least one live entry.
REQ-016 SHALL have pending_rd  output  5  destination of buffer head (0 when empty).
REQ-017 SHALL have pending_count  output  $clog2(DEPTH)+1  live-entry count.

Function
REQ-018 Accepted M result (m_acc) with rd==0 SHALL be discarded; p_wr_en with p_rd==0 SHALL never assert rf_we.
REQ-019 Exactly one register-file write per cycle; rf_* outputs combinational from current inputs and buffer state.
REQ-020 Priority: buffer head when buffer full; else pipeline write; else buffer head; else bypassed m_acc.
REQ-021 Bypass: m_acc with empty buffer and no pipeline write SHALL write rf same cycle (zero latency), not enqueued.
REQ-022 m_acc not written same cycle SHALL be enqueued in arrival order.
REQ-023 stall_wb SHALL be 1 exactly when p_wr_en && p_rd!=0 && buffer full; pipeline write then not performed.
REQ-024 Push and pop in same cycle SHALL both occur; count unchanged; full buffer never drops an m_acc.
REQ-025 Kill: p_wr_en performed to rd X SHALL invalidate every buffered entry with rd==X that cycle (M is older).
REQ-026 m_acc with m_rd==p_rd in a cycle where the pipeline write is performed SHALL be discarded.
REQ-027 Killed entries SHALL be skipped at head without consuming an rf write cycle; pending_count excludes them.
REQ-028 pending_valid/pending_rd SHALL reflect first live entry, updated the cycle after push/kill/pop.
REQ-029 Pointers SHALL wrap modulo DEPTH; full/empty derived from count, not pointer equality.

Reset
REQ-030 resetn==0 at a clock edge SHALL empty buffer, clear all valid bits, pointers and count to 0.
REQ-031 During reset rf_we SHALL be 0, stall_wb 0, pending_valid 0, pending_rd 0, pending_count 0.
REQ-032 Reset mid-operation SHALL discard buffered results without issuing their writes.

Structure
REQ-033 Package m_wb_pkg SHALL hold wb_entry_t (valid, rd[4:0], data[31:0]) and DEFAULT_DEPTH.
REQ-034 Buffer SHALL be sub-module m_wb_fifo (push, pop, kill-by-rd, head outputs); arbitration in top.

Verification
REQ-035 m_acc rd=5 data=0x12345678, buffer empty, p_wr_en=0 -> same cycle rf_we=1, waddr=5, wdata=0x12345678; count 0.
REQ-036 m_acc rd=3 with p_wr_en rd=4 -> cycle0 writes x4; cycle1 writes x3; pending_rd=3 for one cycle.
REQ-037 Two buffered entries (DEPTH=2), p_wr_en rd=7 -> stall_wb=1, head written; next cycle x7 written, stall_wb=0.
REQ-038 Buffered rd=9 data=0xAAAA, then p_wr_en rd=9 data=0xBBBB -> x9 final 0xBBBB; 0xAAAA never written.
REQ-039 m_acc rd=0 and p_wr_en rd=0 -> rf_we=0, count 0.
REQ-040 Buffer full, resetn=0 one cycle -> no rf writes, pending_valid=0, count 0 after edge.
